// File: rtl/map_ss_if.sv
// Save-state sequencer bus: request/status handshake, buffer RAM port and
// mapper save-state port.
interface map_ss_if;
  logic       save_req;
  logic       load_req;
  logic       abort;
  logic       busy;
  logic       done;
  logic       aborted;
  logic [7:0] buf_addr;
  logic [7:0] buf_wdat;
  logic       buf_we;
  logic [7:0] buf_rdat;
  logic       ss_act;
  logic [7:0] ss_addr;
  logic       ss_we;
  logic [7:0] ss_dat;
  logic       ss_stb;
  logic [7:0] ss_rdat;

  modport master (
    input  save_req, load_req, abort, buf_rdat, ss_rdat,
    output busy, done, aborted, buf_addr, buf_wdat, buf_we,
           ss_act, ss_addr, ss_we, ss_dat, ss_stb
  );

  modport slave (
    output save_req, load_req, abort, buf_rdat, ss_rdat,
    input  busy, done, aborted, buf_addr, buf_wdat, buf_we,
           ss_act, ss_addr, ss_we, ss_dat, ss_stb
  );
endinterface

// File: rtl/map_ss_seq.sv
// Save-state sequencer: walks the mapper save-state registers, copying them
// into a byte buffer (save) or strobing buffer bytes back into the mapper (load).
module map_ss_seq #(
  parameter int unsigned N_REGS    = 128,
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned STB_CYC   = 2
) (
  input  logic      clk,
  input  logic      rst,
  map_ss_if.master  bus
);

  localparam int unsigned CNT_MAX = (SETUP_CYC > STB_CYC) ? SETUP_CYC : STB_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [7:0]       LAST_IDX   = 8'(N_REGS - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STB_LAST   = CNT_W'(STB_CYC - 1);

  typedef enum logic [2:0] {
    IDLE, S_SETUP, S_CAP, L_FETCH, L_SETUP, L_STB, L_HOLD, DONE
  } state_t;

  state_t           state, state_nxt;
  logic [7:0]       idx, idx_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [7:0]       ss_dat_q, ss_dat_nxt;
  logic             aborted_q, aborted_nxt;
  logic             last;

  assign last = (idx == LAST_IDX);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= 8'd0;
      cnt       <= '0;
      ss_dat_q  <= 8'd0;
      aborted_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      cnt       <= cnt_nxt;
      ss_dat_q  <= ss_dat_nxt;
      aborted_q <= aborted_nxt;
    end
  end

  // Next-state, index, cycle counter and load-data capture
  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    ss_dat_nxt  = ss_dat_q;
    aborted_nxt = 1'b0;
    case (state)
      IDLE: begin
        idx_nxt = 8'd0;
        if (bus.save_req)      state_nxt = S_SETUP;
        else if (bus.load_req) state_nxt = L_FETCH;
      end
      S_SETUP: if (cnt == SETUP_LAST) state_nxt = S_CAP;
      S_CAP: begin
        if (last) state_nxt = DONE;
        else begin
          idx_nxt   = 8'(idx + 8'd1);
          state_nxt = S_SETUP;
        end
      end
      L_FETCH: begin
        ss_dat_nxt = bus.buf_rdat;
        state_nxt  = L_SETUP;
      end
      L_SETUP: if (cnt == SETUP_LAST) state_nxt = L_STB;
      L_STB:   if (cnt == STB_LAST)   state_nxt = L_HOLD;
      L_HOLD: begin
        if (last) state_nxt = DONE;
        else begin
          idx_nxt   = 8'(idx + 8'd1);
          state_nxt = L_FETCH;
        end
      end
      DONE: begin
        state_nxt  = IDLE;
        idx_nxt    = 8'd0;
        ss_dat_nxt = 8'd0;
      end
      default: state_nxt = IDLE;
    endcase
    if (bus.abort && (state != IDLE) && (state != DONE)) begin
      state_nxt   = IDLE;
      idx_nxt     = 8'd0;
      ss_dat_nxt  = 8'd0;
      aborted_nxt = 1'b1;
    end
    cnt_nxt = (state_nxt != state) ? '0 : CNT_W'(cnt + CNT_W'(1));
  end

  // Output decode
  always_comb begin
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    bus.aborted  = aborted_q;
    bus.buf_addr = idx;
    bus.buf_wdat = 8'd0;
    bus.buf_we   = 1'b0;
    bus.ss_act   = 1'b0;
    bus.ss_addr  = 8'd0;
    bus.ss_we    = 1'b0;
    bus.ss_dat   = ss_dat_q;
    bus.ss_stb   = 1'b0;
    if (state != IDLE) begin
      bus.busy    = 1'b1;
      bus.ss_act  = 1'b1;
      bus.ss_addr = idx;
    end
    case (state)
      S_CAP: begin
        bus.buf_we   = 1'b1;
        bus.buf_wdat = bus.ss_rdat;
      end
      L_SETUP: bus.ss_we = 1'b1;
      L_STB: begin
        bus.ss_we  = 1'b1;
        bus.ss_stb = 1'b1;
      end
      L_HOLD: begin
        bus.ss_we = 1'b1;
        // Present the next index early so the 1-cycle RAM has it ready in L_FETCH
        if (!last) bus.buf_addr = 8'(idx + 8'd1);
      end
      DONE: bus.done = 1'b1;
      default: ;
    endcase
  end

endmodule
